pe_array: RTL and testbench

Output-stationary systolic multiply-accumulate array of ROWS x COLS processing elements (PEs). Activations enter on the left edge and move right one column per cycle; weights enter on the top edge and move down one row per cycle; each PE keeps its own 32-bit accumulator. The block is the compute core of the accelerator datapath. Input skewing and result readout sequencing belong to the surrounding controller.

---
 rtl/pe_pkg.sv | 22 ++
 rtl/pe_array_cell.sv | 74 +++++++
 rtl/pe_array.sv | 72 +++++++
 tb/tb_pe_array.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared widths, types and the multiply helper for the systolic MAC array.
// Operand data is 8-bit unsigned. The 16-bit product is zero-extended into the
// 32-bit accumulator, and the accumulator wraps modulo 2^32.
package pe_pkg;

  localparam int DATA_W = 8;
  localparam int PROD_W = 16;
  localparam int ACC_W  = 32;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [ACC_W-1:0]  acc_t;

  // Both operands are widened to 16 bits before the multiply, so the full
  // 8x8 product is kept before zero-extension to the accumulator width.
  function automatic acc_t mul_ext(input data_t a, input data_t w);
    prod_t p;
    p = prod_t'(a) * prod_t'(w);
    return acc_t'(p);
  endfunction

endpackage

// File: rtl/pe_array_cell.sv
// pe_cell: one output-stationary processing element.
// Ports:
//   clk, rstn            clock, synchronous active-high reset (rstn=1 resets)
//   a_in, w_in, f_in     activation, weight and fire token arriving at this PE
//   a_out, w_out, f_out  registered copies passed to the right / down neighbours
//   acc                  32-bit accumulator register
//   outvalid             result-valid flag, set when the fire token falls
module pe_cell
  import pe_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  data_t a_in,
  input  data_t w_in,
  input  logic  f_in,
  output data_t a_out,
  output data_t w_out,
  output logic  f_out,
  output acc_t  acc,
  output logic  outvalid
);

  data_t a_q, a_d;
  data_t w_q, w_d;
  logic  f_q, f_d;
  acc_t  acc_q, acc_d;
  logic  outvalid_q, outvalid_d;
  acc_t  product;

  // The forwarded fire token and the previous-cycle fire are the same flop:
  // both are simply f_in delayed by one cycle.
  always_comb begin
    a_d        = a_in;
    w_d        = w_in;
    f_d        = f_in;
    acc_d      = acc_q;
    outvalid_d = outvalid_q;
    product    = mul_ext(a_in, w_in);
    if (f_in) begin
      if (!f_q) begin
        // Rising token: start a fresh result and drop the old one.
        acc_d      = product;
        outvalid_d = 1'b0;
      end else begin
        acc_d = acc_q + product;
      end
    end else if (f_q) begin
      outvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      a_q        <= '0;
      w_q        <= '0;
      f_q        <= 1'b0;
      acc_q      <= '0;
      outvalid_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      w_q        <= w_d;
      f_q        <= f_d;
      acc_q      <= acc_d;
      outvalid_q <= outvalid_d;
    end
  end

  assign a_out    = a_q;
  assign w_out    = w_q;
  assign f_out    = f_q;
  assign acc      = acc_q;
  assign outvalid = outvalid_q;

endmodule

// File: rtl/pe_array.sv
// pe_array: ROWS x COLS output-stationary systolic MAC array.
// Ports:
//   clk, rstn   clock, synchronous active-high reset (rstn=1 resets)
//   fire        accumulate-enable token, enters at PE(0,0)
//   in_w[c]     weight feeding the top of column c
//   in_a[r]     activation feeding the left of row r
//   outs[i]     accumulator of PE(r,c), i = r*COLS+c
//   outvalids   result-valid flag of PE(r,c), same indexing
// Activations move right and weights move down one PE per cycle. The fire token
// walks down column 0 and then right along each row, so it reaches PE(r,c)
// after r+c cycles.
module pe_array
  import pe_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic  clk,
  input  logic  rstn,
  input  logic  fire,
  input  data_t in_w      [0:COLS-1],
  input  data_t in_a      [0:ROWS-1],
  output acc_t  outs      [0:ROWS*COLS-1],
  output logic  outvalids [0:ROWS*COLS-1]
);

  data_t a_link [ROWS][COLS];
  data_t w_link [ROWS][COLS];
  logic  f_link [ROWS][COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      data_t a_src;
      data_t w_src;
      logic  f_src;

      if (c == 0) begin : g_a_edge
        assign a_src = in_a[r];
      end else begin : g_a_link
        assign a_src = a_link[r][c-1];
      end

      if (r == 0) begin : g_w_edge
        assign w_src = in_w[c];
      end else begin : g_w_link
        assign w_src = w_link[r-1][c];
      end

      if (r == 0 && c == 0) begin : g_f_root
        assign f_src = fire;
      end else if (c == 0) begin : g_f_down
        assign f_src = f_link[r-1][0];
      end else begin : g_f_right
        assign f_src = f_link[r][c-1];
      end

      pe_cell u_pe (
        .clk      (clk),
        .rstn     (rstn),
        .a_in     (a_src),
        .w_in     (w_src),
        .f_in     (f_src),
        .a_out    (a_link[r][c]),
        .w_out    (w_link[r][c]),
        .f_out    (f_link[r][c]),
        .acc      (outs[r*COLS+c]),
        .outvalid (outvalids[r*COLS+c])
      );
    end
  end

endmodule

// File: tb/tb_pe_array.sv
module tb_pe_array;
  import pe_pkg::*;

  localparam int R = 8;
  localparam int C = 8;

  logic  clk = 1'b0;
  logic  rstn;
  logic  fire;
  logic  fire2;
  data_t in_w [0:C-1];
  data_t in_a [0:R-1];
  acc_t  outs [0:R*C-1];
  logic  outvalids [0:R*C-1];
  data_t in_w2 [0:1];
  data_t in_a2 [0:1];
  acc_t  outs2 [0:3];
  logic  outvalids2 [0:3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pe_array #(.ROWS(R), .COLS(C)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .fire      (fire),
    .in_w      (in_w),
    .in_a      (in_a),
    .outs      (outs),
    .outvalids (outvalids)
  );

  pe_array #(.ROWS(2), .COLS(2)) dut2 (
    .clk       (clk),
    .rstn      (rstn),
    .fire      (fire2),
    .in_w      (in_w2),
    .in_a      (in_a2),
    .outs      (outs2),
    .outvalids (outvalids2)
  );

  task automatic set_inputs(input data_t w, input data_t a);
    for (int i = 0; i < C; i++) in_w[i] = w;
    for (int i = 0; i < R; i++) in_a[i] = a;
    for (int i = 0; i < 2; i++) begin
      in_w2[i] = '0;
      in_a2[i] = '0;
    end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < C; i++) in_w[i] = data_t'($urandom_range(255));
    for (int i = 0; i < R; i++) in_a[i] = data_t'($urandom_range(255));
    for (int i = 0; i < 2; i++) begin
      in_w2[i] = data_t'($urandom_range(255));
      in_a2[i] = data_t'($urandom_range(255));
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn  = 1'b1;
    fire  = 1'b0;
    fire2 = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn  = 1'b1;
    fire  = 1'b1;
    fire2 = 1'b1;
    randomize_inputs();
    for (int cyc = 0; cyc < 3; cyc++) begin
      if (cyc == 2) begin
        rstn  = 1'b0;
        fire  = 1'b0;
        fire2 = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < R*C; i++) begin
        checks++;
        if (outs[i] !== 32'd0) begin
          errors++;
          $display("FAIL reset_acc cyc%0d pe%0d got %0d want 0", cyc, i, outs[i]);
        end
        checks++;
        if (outvalids[i] !== 1'b0) begin
          errors++;
          $display("FAIL reset_valid cyc%0d pe%0d got %b want 0", cyc, i, outvalids[i]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (outs2[i] !== 32'd0 || outvalids2[i] !== 1'b0) begin
          errors++;
          $display("FAIL reset_small cyc%0d pe%0d got acc=%0d v=%b want acc=0 v=0",
                   cyc, i, outs2[i], outvalids2[i]);
        end
      end
      @(negedge clk);
      randomize_inputs();
    end
  endtask

  // Constant operands, fire high for n cycles starting at edge 0. When rst_k >= 0
  // reset is pulsed on edge rst_k while fire stays high; the surviving tokens form
  // a new burst starting at edge rst_k+1.
  task automatic run_burst(input string tag, input data_t w, input data_t a,
                           input int n, input int rst_k, input int edges,
                           input acc_t final_exp);
    acc_t prod;
    acc_t exp_acc;
    logic exp_v;
    int   d, ts, ne, cnt, idx;
    prod = acc_t'(w) * acc_t'(a);
    apply_reset();
    set_inputs(w, a);
    for (int k = 0; k < edges; k++) begin
      rstn = (k == rst_k);
      fire = (k < n);
      @(posedge clk);
      #1;
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C; c++) begin
          d   = r + c;
          idx = r*C + c;
          if (rst_k >= 0 && k == rst_k) begin
            exp_acc = '0;
            exp_v   = 1'b0;
          end else begin
            ts  = (rst_k >= 0 && k > rst_k) ? rst_k + 1 : 0;
            ne  = n - ts;
            cnt = k - ts - d + 1;
            if (cnt < 0)  cnt = 0;
            if (cnt > ne) cnt = ne;
            exp_acc = acc_t'(cnt) * prod;
            exp_v   = (k >= ts + ne + d);
          end
          checks++;
          if (outs[idx] !== exp_acc) begin
            errors++;
            $display("FAIL %s_acc edge%0d pe%0d got %0d want %0d", tag, k, idx, outs[idx], exp_acc);
          end
          checks++;
          if (outvalids[idx] !== exp_v) begin
            errors++;
            $display("FAIL %s_valid edge%0d pe%0d got %b want %b", tag, k, idx, outvalids[idx], exp_v);
          end
        end
      end
      @(negedge clk);
    end
    rstn = 1'b0;
    fire = 1'b0;
    for (int i = 0; i < R*C; i++) begin
      checks++;
      if (outs[i] !== final_exp || outvalids[i] !== 1'b1) begin
        errors++;
        $display("FAIL %s_final pe%0d got acc=%0d v=%b want acc=%0d v=1",
                 tag, i, outs[i], outvalids[i], final_exp);
      end
    end
  endtask

  task automatic test_restart();
    logic fseq [8];
    int   exp_acc [8];
    logic exp_v [8];
    fseq    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_acc = '{1, 2, 3, 4, 4, 6, 12, 12};
    exp_v   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      if (k < 5) set_inputs(8'd1, 8'd1);
      else       set_inputs(8'd2, 8'd3);
      fire = fseq[k];
      @(posedge clk);
      #1;
      checks++;
      if (outs[0] !== acc_t'(exp_acc[k])) begin
        errors++;
        $display("FAIL restart_acc edge%0d got %0d want %0d", k, outs[0], exp_acc[k]);
      end
      checks++;
      if (outvalids[0] !== exp_v[k]) begin
        errors++;
        $display("FAIL restart_valid edge%0d got %b want %b", k, outvalids[0], exp_v[k]);
      end
      @(negedge clk);
    end
    fire = 1'b0;
  endtask

  task automatic test_matmul();
    int   am [2][2];
    int   bm [2][2];
    int   want [4];
    int   j;
    am   = '{'{1, 2}, '{3, 4}};
    bm   = '{'{5, 6}, '{7, 8}};
    want = '{19, 22, 43, 50};
    apply_reset();
    set_inputs(8'd0, 8'd0);
    for (int k = 0; k < 6; k++) begin
      for (int l = 0; l < 2; l++) begin
        j = k - l;
        in_a2[l] = (j >= 0 && j < 2) ? data_t'(am[l][j]) : '0;
        in_w2[l] = (j >= 0 && j < 2) ? data_t'(bm[j][l]) : '0;
      end
      fire2 = (k < 2);
      @(posedge clk);
      #1;
      if (k == 1) begin
        checks++;
        if (outs2[0] !== 32'd19 || outvalids2[0] !== 1'b0) begin
          errors++;
          $display("FAIL matmul_pe0_edge1 got acc=%0d v=%b want acc=19 v=0", outs2[0], outvalids2[0]);
        end
      end
      if (k == 3) begin
        checks++;
        if (outvalids2[3] !== 1'b0) begin
          errors++;
          $display("FAIL matmul_pe3_early_valid got %b want 0", outvalids2[3]);
        end
      end
      @(negedge clk);
    end
    fire2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outs2[i] !== acc_t'(want[i])) begin
        errors++;
        $display("FAIL matmul_acc pe%0d got %0d want %0d", i, outs2[i], want[i]);
      end
      checks++;
      if (outvalids2[i] !== 1'b1) begin
        errors++;
        $display("FAIL matmul_valid pe%0d got %b want 1", i, outvalids2[i]);
      end
    end
  endtask

  initial begin
    rstn  = 1'b1;
    fire  = 1'b0;
    fire2 = 1'b0;
    set_inputs(8'd0, 8'd0);
    test_reset();
    run_burst("uniform", 8'd1, 8'd2, 10, -1, 26, 32'd20);
    run_burst("maxop", 8'd255, 8'd255, 10, -1, 26, 32'd650250);
    test_restart();
    test_matmul();
    run_burst("midreset", 8'd1, 8'd2, 10, 4, 26, 32'd10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
